// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-level elevator controller.
package elevator_pkg;

    localparam int LEVEL_W     = 2;
    localparam int QUEUE_DEPTH = 4;
    localparam int QUEUE_W     = LEVEL_W * QUEUE_DEPTH;
    localparam int TAIL_W      = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        ARRIVE,
        DOOR
    } state_e;

    // Entry idx of a packed request queue; entry 0 is the head.
    function automatic logic [LEVEL_W-1:0] queue_entry(
        input logic [QUEUE_W-1:0] q,
        input int unsigned        idx
    );
        return LEVEL_W'(q >> (LEVEL_W * idx));
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter that holds at zero; zero_o flags the final cycle of a wait.
module elev_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins, otherwise step down and hold at zero
    always_comb begin
        // NOTE: count_d is given a default before any branch so no path leaves it unassigned, which would infer a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register in the design samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Car controller: commits the external queue-update results every cycle and
// runs the move/arrive/door sequence that serves the queue head in order.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [QUEUE_W-1:0] next_queue_sub,
    input  logic [TAIL_W-1:0]  next_tail_sub,
    input  logic               stop_at_pos_lvl,
    output logic [QUEUE_W-1:0] queue,
    output logic [TAIL_W-1:0]  tail,
    output logic [LEVEL_W-1:0] pos_lvl,
    output logic               move_up,
    output logic               move_down,
    output logic               door_open,
    output logic [LEVEL_W-1:0] target_lvl
);

    localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] TRAVEL_VAL = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_VAL   = TIMER_W'(DOOR_CYCLES - 1);

    state_e             state_q;
    logic [QUEUE_W-1:0] queue_q;
    logic [TAIL_W-1:0]  tail_q;
    logic [LEVEL_W-1:0] pos_lvl_q;
    logic [LEVEL_W-1:0] target_lvl_q;
    logic               dir_up_q;
    logic               move_up_q;
    logic               move_down_q;
    logic               door_open_q;

    logic [LEVEL_W-1:0] head_lvl;
    logic               head_up;
    logic               go_door;
    logic               go_travel;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_zero;

    assign head_lvl = queue_entry(queue_q, 0);
    assign head_up  = (head_lvl > pos_lvl_q);

    // A stop at the current level opens the door from any state except MOVE,
    // where the car has left and the absorbed press is deliberately ignored.
    assign go_door   = stop_at_pos_lvl && (state_q != MOVE);
    assign go_travel = !stop_at_pos_lvl &&
                       (((state_q == IDLE)   && (tail_q != '0)) ||
                        ((state_q == ARRIVE) && (pos_lvl_q != target_lvl_q)));

    assign timer_load = go_door || go_travel;
    assign timer_val  = go_door ? DOOR_VAL : TRAVEL_VAL;

    elev_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Queue commit plus the move/arrive/door state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            queue_q      <= '0;
            tail_q       <= '0;
            pos_lvl_q    <= '0;
            target_lvl_q <= '0;
            dir_up_q     <= 1'b0;
            move_up_q    <= 1'b0;
            move_down_q  <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            queue_q <= next_queue_sub;
            tail_q  <= next_tail_sub;
            unique case (state_q)
                IDLE: begin
                    if (go_door) begin
                        state_q     <= DOOR;
                        door_open_q <= 1'b1;
                    end else if (go_travel) begin
                        state_q      <= MOVE;
                        target_lvl_q <= head_lvl;
                        dir_up_q     <= head_up;
                        move_up_q    <= head_up;
                        move_down_q  <= !head_up;
                    end
                end
                MOVE: begin
                    if (timer_zero) begin
                        state_q     <= ARRIVE;
                        pos_lvl_q   <= dir_up_q ? pos_lvl_q + LEVEL_W'(1) : pos_lvl_q - LEVEL_W'(1);
                        move_up_q   <= 1'b0;
                        move_down_q <= 1'b0;
                    end
                end
                ARRIVE: begin
                    if (go_door) begin
                        state_q     <= DOOR;
                        door_open_q <= 1'b1;
                    end else if (go_travel) begin
                        state_q     <= MOVE;
                        move_up_q   <= dir_up_q;
                        move_down_q <= !dir_up_q;
                    end else begin
                        // Defensive: arrived at the target without a queued stop.
                        state_q <= IDLE;
                    end
                end
                DOOR: begin
                    if (!stop_at_pos_lvl && timer_zero) begin
                        state_q     <= IDLE;
                        door_open_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign queue      = queue_q;
    assign tail       = tail_q;
    assign pos_lvl    = pos_lvl_q;
    assign target_lvl = target_lvl_q;
    assign move_up    = move_up_q;
    assign move_down  = move_down_q;
    assign door_open  = door_open_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench: plays the external queue-update stage around the
// controller and compares every cycle against a behavioural car model.
module tb_elevator_ctrl;

    localparam int TB_T = 2;
    localparam int TB_D = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] next_queue_sub;
    logic [2:0] next_tail_sub;
    logic       stop_at_pos_lvl;
    logic [7:0] queue;
    logic [2:0] tail;
    logic [1:0] pos_lvl;
    logic       move_up;
    logic       move_down;
    logic       door_open;
    logic [1:0] target_lvl;

    bit         press_v;
    logic [1:0] press_lvl;
    logic [11:0] stage_out;

    int n_checks = 0;
    int n_pass   = 0;

    elevator_ctrl #(
        .TRAVEL_CYCLES (TB_T),
        .DOOR_CYCLES   (TB_D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .next_queue_sub  (next_queue_sub),
        .next_tail_sub   (next_tail_sub),
        .stop_at_pos_lvl (stop_at_pos_lvl),
        .queue           (queue),
        .tail            (tail),
        .pos_lvl         (pos_lvl),
        .move_up         (move_up),
        .move_down       (move_down),
        .door_open       (door_open),
        .target_lvl      (target_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    endtask

    // Queue-update stage: append a new press (no duplicates, drop when full),
    // then remove the car's level if present and flag the stop.
    function automatic logic [11:0] stage_fn(input logic [7:0] q, input logic [2:0] t,
                                             input logic [1:0] pos, input bit pv,
                                             input logic [1:0] pl);
        int lst[$];
        int hit = -1;
        bit dup = 1'b0;
        bit stop = 1'b0;
        logic [7:0] nq = '0;
        for (int i = 0; i < 4 && i < int'(t); i++) lst.push_back(int'(q[2*i +: 2]));
        if (pv) begin
            for (int i = 0; i < lst.size(); i++) if (lst[i] == int'(pl)) dup = 1'b1;
            if (!dup && lst.size() < 4) lst.push_back(int'(pl));
        end
        for (int i = 0; i < lst.size(); i++) if (hit < 0 && lst[i] == int'(pos)) hit = i;
        if (hit >= 0) begin
            lst.delete(hit);
            stop = 1'b1;
        end
        for (int i = 0; i < lst.size(); i++) nq[2*i +: 2] = 2'(lst[i]);
        return {stop, 3'(lst.size()), nq};
    endfunction

    always_comb stage_out = stage_fn(queue, tail, pos_lvl, press_v, press_lvl);
    assign next_queue_sub  = stage_out[7:0];
    assign next_tail_sub   = stage_out[10:8];
    assign stop_at_pos_lvl = stage_out[11];

    // ---------------- behavioural model ----------------
    typedef enum {PH_IDLE, PH_TRAVEL, PH_ARRIVE, PH_DOOR} phase_e;
    phase_e     m_phase  = PH_IDLE;
    logic [7:0] m_q      = '0;
    int         m_tail   = 0;
    int         m_pos    = 0;
    int         m_target = 0;
    bit         m_up     = 1'b0;
    int         m_left   = 0;   // cycles still to spend in the current phase

    task automatic model_reset();
        m_phase = PH_IDLE; m_q = '0; m_tail = 0; m_pos = 0;
        m_target = 0; m_up = 1'b0; m_left = 0;
    endtask

    task automatic model_step();
        logic [11:0] s;
        s = stage_fn(m_q, 3'(m_tail), 2'(m_pos), press_v, press_lvl);
        case (m_phase)
            PH_IDLE: begin
                if (s[11]) begin
                    m_phase = PH_DOOR; m_left = TB_D;
                end else if (m_tail != 0) begin
                    m_target = int'(m_q[1:0]);
                    m_up     = (m_target > m_pos);
                    m_phase  = PH_TRAVEL; m_left = TB_T;
                end
            end
            PH_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    m_pos   = m_up ? m_pos + 1 : m_pos - 1;
                    m_phase = PH_ARRIVE;
                end
            end
            PH_ARRIVE: begin
                if (s[11]) begin
                    m_phase = PH_DOOR; m_left = TB_D;
                end else if (m_pos != m_target) begin
                    m_phase = PH_TRAVEL; m_left = TB_T;
                end else begin
                    m_phase = PH_IDLE;
                end
            end
            PH_DOOR: begin
                if (s[11]) m_left = TB_D;
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
            end
        endcase
        m_q    = s[7:0];
        m_tail = int'(s[10:8]);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [17:0] dut_vec;
    logic [17:0] exp_vec;
    int prev_pos = 0;

    assign dut_vec = {queue, tail, pos_lvl, move_up, move_down, door_open, target_lvl};
    assign exp_vec = {m_q, 3'(m_tail), 2'(m_pos),
                      (m_phase == PH_TRAVEL) && m_up, (m_phase == PH_TRAVEL) && !m_up,
                      m_phase == PH_DOOR, 2'(m_target)};

    initial begin
        int diff;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_pos = 0;
            else begin
                check("outputs", int'(dut_vec), int'(exp_vec));
                if (int'(pos_lvl) != prev_pos) begin
                    diff = int'(pos_lvl) - prev_pos;
                    if (diff < 0) diff = -diff;
                    check("pos_step", diff, 1);
                end
                prev_pos = int'(pos_lvl);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int lvl);
        press_v = 1'b1; press_lvl = 2'(lvl);
        @(negedge clk);
        press_v = 1'b0;
    endtask

    task automatic wait_door(input string name, output int k);
        k = 0;
        while (!door_open && k < 200) begin
            @(negedge clk); k++;
        end
        if (!door_open) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_closed();
        int k = 0;
        while (door_open && k < 200) begin
            @(negedge clk); k++;
        end
        if (door_open) check("close_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got running, want finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int k, cnt, seq, last, moved;
        press_v = 1'b0; press_lvl = '0; rst_n = 1'b0;
        #12;
        check("rst_queue",  int'(queue), 0);
        check("rst_tail",   int'(tail), 0);
        check("rst_pos",    int'(pos_lvl), 0);
        check("rst_target", int'(target_lvl), 0);
        check("rst_moves",  int'({move_up, move_down}), 0);
        check("rst_door",   int'(door_open), 0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Current-level press: door for exactly TB_D cycles, queue untouched.
        press(0);
        check("cur_door_rise", int'(door_open), 1);
        cnt = 0;
        while (door_open && cnt < 100) begin cnt++; @(negedge clk); end
        check("cur_door_len", cnt, TB_D);
        check("cur_tail", int'(tail), 0);

        // Simple trip 0 -> 3.
        press(3);
        check("trip_tail", int'(tail), 1);
        check("trip_wait", int'(move_up), 0);
        @(negedge clk);
        check("trip_up", int'(move_up), 1);
        k = 2; seq = 0; last = int'(pos_lvl);
        while (!door_open && k < 200) begin
            @(negedge clk); k++;
            if (int'(pos_lvl) != last) begin
                seq = seq * 10 + int'(pos_lvl); last = int'(pos_lvl);
            end
        end
        // The door opens the cycle after the final ARRIVE.
        check("trip_door_cycle", k, 2 + 3 * (TB_T + 1));
        check("trip_pos_seq", seq, 123);
        check("trip_tail_done", int'(tail), 0);
        wait_closed();

        // Opportunistic stop: head 0, then 1, car at 3 -> stops at 1 first.
        press_v = 1'b1; press_lvl = 2'd0;
        @(negedge clk);
        press_lvl = 2'd1;
        @(negedge clk);
        press_v = 1'b0;
        check("opp_tail2", int'(tail), 2);
        check("opp_queue2", int'(queue), 'h04);
        wait_door("opp_first", k);
        check("opp_first_cycle", k + 2, 2 + 2 * (TB_T + 1));
        check("opp_first_pos", int'(pos_lvl), 1);
        check("opp_first_tail", int'(tail), 1);
        wait_closed();
        wait_door("opp_second", k);
        check("opp_second_pos", int'(pos_lvl), 0);

        // Door extension: press the current level when one cycle remains after this.
        @(negedge clk);
        @(negedge clk);
        press(0);
        cnt = 3;
        while (door_open && cnt < 100) begin cnt++; @(negedge clk); end
        check("ext_door_len", cnt, 2 * TB_D - 1);
        check("ext_tail", int'(tail), 0);

        // Departed-level press during MOVE is absorbed, no return trip.
        press(2);
        @(negedge clk);
        check("dep_up", int'(move_up), 1);
        press(0);
        check("dep_tail", int'(tail), 1);
        check("dep_queue", int'(queue), 'h02);
        wait_door("dep_door", k);
        check("dep_pos", int'(pos_lvl), 2);
        wait_closed();
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_up || move_down || door_open || tail != 0) moved = 1;
        end
        check("dep_no_return", moved, 0);

        // Asynchronous reset in the middle of a trip.
        press(0);
        @(negedge clk);
        check("rstm_down", int'(move_down), 1);
        #2 rst_n = 1'b0;
        #1 check("rstm_outputs", int'(dut_vec), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (move_up || move_down || door_open || tail != 0) moved = 1;
        end
        check("rstm_idle", moved, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            press_v   = ($urandom_range(0, 3) == 0);
            press_lvl = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        press_v = 1'b0;
        repeat (200) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
